// File: rtl/display_pkg.sv
// Shared types and defaults for the display sequencer: FSM state encoding and
// the default counter/channel widths used by the top and its timing counter.
package display_pkg;

  localparam int CNT_W_DEF  = 10;
  localparam int ADDR_W_DEF = 16;
  localparam int NUM_CH_DEF = 3;

  // Channel counter is sized for the largest legal NUM_CH (4).
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_HBLANK = 2'd2,
    ST_ACTIVE = 2'd3
  } disp_state_e;

endpackage

// File: rtl/display_timing_cnt.sv
// Channel/pixel/line counters for the display sequencer. The pixel counter
// advances on channel wrap; terminal-count flags are decoded for the FSM.
module display_timing_cnt
  import display_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              seg_clr_i,
  input  logic              line_inc_i,
  input  logic              line_clr_i,
  input  logic [CNT_W:0]    seg_len_i,
  output logic [CH_W-1:0]   ch_cnt_o,
  output logic [CNT_W:0]    px_cnt_o,
  output logic [CNT_W-1:0]  line_cnt_o,
  output logic              ch_last_o,
  output logic              px_last_o
);

  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W:0]   px_q, px_d;
  logic [CNT_W-1:0] line_q, line_d;

  assign ch_last_o  = (ch_q == CH_MAX);
  assign px_last_o  = (px_q == (seg_len_i - (CNT_W+1)'(1)));
  assign ch_cnt_o   = ch_q;
  assign px_cnt_o   = px_q;
  assign line_cnt_o = line_q;

  always_comb begin
    ch_d   = ch_q;
    px_d   = px_q;
    line_d = line_q;
    if (en_i) begin
      if (ch_last_o) begin
        ch_d = '0;
        px_d = seg_clr_i ? '0 : (px_q + (CNT_W+1)'(1));
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
    if (line_clr_i) begin
      line_d = '0;
    end else if (line_inc_i) begin
      line_d = line_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      px_q   <= '0;
      line_q <= '0;
    end else begin
      ch_q   <= ch_d;
      px_q   <= px_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/display_seq_ctrl.sv
// Double-buffered display read sequencer: walks vblank/hblank/active timing,
// issues per-channel buffer reads and swaps buffers at frame end.
module display_seq_ctrl
  import display_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_display,
  input  logic [CNT_W-1:0]  cfg_hb,
  input  logic [CNT_W-1:0]  cfg_vb,
  input  logic [CNT_W-1:0]  cfg_aip,
  input  logic [CNT_W-1:0]  cfg_ail,
  input  logic [1:0]        buf_full,
  output logic              disp_buf,
  output logic              wr_buf,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              sel_blank,
  output logic              sel_buf,
  output logic              hsync,
  output logic              vsync,
  output logic [1:0]        buf_release,
  output logic              frame_done,
  output logic              repeat_frame,
  output logic              cfg_err
);

  disp_state_e      state_q, state_d;
  logic [CNT_W-1:0] hb_q, hb_d, vb_q, vb_d, aip_q, aip_d, ail_q, ail_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             disp_q, disp_d;
  logic             rdy_q;
  logic             err_hold_q, err_hold_d;
  logic             done_q, done_d, rep_q, rep_d, err_q, err_d;
  logic [1:0]       rel_q, rel_d;

  logic             cnt_en, seg_clr, line_inc, line_clr, frame_end;
  logic [CNT_W:0]   seg_len;
  logic [CH_W-1:0]  ch_cnt;
  logic [CNT_W:0]   px_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             ch_last, px_last, pix_end, line_start;

  logic [CNT_W:0]   line_len_in, vline_len;
  logic             cfg_bad_in;

  logic             vsync_q, hsync_q, rd_en_q, sel_blank_q, sel_buf_q;
  logic             disp_buf_q, wr_buf_q, frame_done_q, repeat_q, cfg_err_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [NUM_CH-1:0] ch_sel_q;
  logic [1:0]       release_q;

  function automatic disp_state_e first_state(input logic [CNT_W-1:0] vb,
                                              input logic [CNT_W-1:0] hb);
    if (vb != '0) return ST_VBLANK;
    if (hb != '0) return ST_HBLANK;
    return ST_ACTIVE;
  endfunction

  assign line_len_in = {1'b0, cfg_hb} + {1'b0, cfg_aip};
  assign cfg_bad_in  = (cfg_aip == '0) || (cfg_ail == '0) || (line_len_in == '0);
  assign vline_len   = {1'b0, hb_q} + {1'b0, aip_q};
  assign pix_end     = ch_last && px_last;
  assign line_start  = (px_cnt == '0) && (ch_cnt == '0);

  always_comb begin
    case (state_q)
      ST_VBLANK: seg_len = vline_len;
      ST_HBLANK: seg_len = {1'b0, hb_q};
      default:   seg_len = {1'b0, aip_q};
    endcase
  end

  display_timing_cnt #(
    .CNT_W  (CNT_W),
    .NUM_CH (NUM_CH)
  ) u_timing_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (cnt_en),
    .seg_clr_i  (seg_clr),
    .line_inc_i (line_inc),
    .line_clr_i (line_clr),
    .seg_len_i  (seg_len),
    .ch_cnt_o   (ch_cnt),
    .px_cnt_o   (px_cnt),
    .line_cnt_o (line_cnt),
    .ch_last_o  (ch_last),
    .px_last_o  (px_last)
  );

  always_comb begin
    state_d    = state_q;
    hb_d       = hb_q;
    vb_d       = vb_q;
    aip_d      = aip_q;
    ail_d      = ail_q;
    addr_d     = addr_q;
    disp_d     = disp_q;
    err_hold_d = err_hold_q;
    done_d     = 1'b0;
    rep_d      = 1'b0;
    rel_d      = 2'b00;
    err_d      = 1'b0;
    cnt_en     = 1'b0;
    seg_clr    = 1'b0;
    line_inc   = 1'b0;
    line_clr   = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A rejected config is reported once, then ignored until cs_display drops.
        if (!cs_display) begin
          err_hold_d = 1'b0;
        end else if (rdy_q && buf_full[0] && !err_hold_q) begin
          if (cfg_bad_in) begin
            err_d      = 1'b1;
            err_hold_d = 1'b1;
          end else begin
            hb_d    = cfg_hb;
            vb_d    = cfg_vb;
            aip_d   = cfg_aip;
            ail_d   = cfg_ail;
            disp_d  = 1'b0;
            state_d = first_state(cfg_vb, cfg_hb);
          end
        end
      end
      ST_VBLANK: begin
        cnt_en = 1'b1;
        if (pix_end) begin
          seg_clr = 1'b1;
          if (line_cnt == (vb_q - CNT_W'(1))) begin
            line_clr = 1'b1;
            state_d  = (hb_q != '0) ? ST_HBLANK : ST_ACTIVE;
          end else begin
            line_inc = 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        cnt_en = 1'b1;
        if (pix_end) begin
          seg_clr = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        cnt_en = 1'b1;
        if (ch_last) addr_d = addr_q + ADDR_W'(1);
        if (pix_end) begin
          seg_clr = 1'b1;
          if (line_cnt == (ail_q - CNT_W'(1))) begin
            frame_end = 1'b1;
          end else begin
            line_inc = 1'b1;
            state_d  = (hb_q != '0) ? ST_HBLANK : ST_ACTIVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame end: swap to the other buffer if the writer filled it, else repeat.
    if (frame_end) begin
      line_clr = 1'b1;
      addr_d   = '0;
      done_d   = 1'b1;
      if (buf_full[~disp_q]) begin
        disp_d        = ~disp_q;
        rel_d[disp_q] = 1'b1;
      end else begin
        rep_d = 1'b1;
      end
      if (!cs_display) begin
        state_d = ST_IDLE;
      end else if (cfg_bad_in) begin
        err_d      = 1'b1;
        err_hold_d = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        hb_d    = cfg_hb;
        vb_d    = cfg_vb;
        aip_d   = cfg_aip;
        ail_d   = cfg_ail;
        state_d = first_state(cfg_vb, cfg_hb);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hb_q       <= '0;
      vb_q       <= '0;
      aip_q      <= '0;
      ail_q      <= '0;
      addr_q     <= '0;
      disp_q     <= 1'b0;
      rdy_q      <= 1'b0;
      err_hold_q <= 1'b0;
      done_q     <= 1'b0;
      rep_q      <= 1'b0;
      rel_q      <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hb_q       <= hb_d;
      vb_q       <= vb_d;
      aip_q      <= aip_d;
      ail_q      <= ail_d;
      addr_q     <= addr_d;
      disp_q     <= disp_d;
      rdy_q      <= 1'b1;
      err_hold_q <= err_hold_d;
      done_q     <= done_d;
      rep_q      <= rep_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
    end
  end

  // Output stage: every output is a flop decoded from the current state, so
  // buffer-select and event pulses stay aligned with the data strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      ch_sel_q     <= '0;
      sel_blank_q  <= 1'b0;
      sel_buf_q    <= 1'b0;
      disp_buf_q   <= 1'b0;
      wr_buf_q     <= 1'b1;
      frame_done_q <= 1'b0;
      repeat_q     <= 1'b0;
      release_q    <= 2'b00;
      cfg_err_q    <= 1'b0;
    end else begin
      vsync_q      <= (state_q == ST_VBLANK) && line_start && (line_cnt == '0);
      hsync_q      <= line_start && ((state_q == ST_HBLANK) ||
                                     ((state_q == ST_ACTIVE) && (hb_q == '0)));
      rd_en_q      <= (state_q == ST_ACTIVE);
      rd_addr_q    <= (state_q == ST_ACTIVE) ? addr_q : '0;
      ch_sel_q     <= (state_q == ST_ACTIVE) ? (NUM_CH'(1) << ch_cnt) : '0;
      sel_blank_q  <= (state_q == ST_VBLANK) || (state_q == ST_HBLANK);
      sel_buf_q    <= (state_q == ST_ACTIVE);
      disp_buf_q   <= disp_q;
      wr_buf_q     <= ~disp_q;
      frame_done_q <= done_q;
      repeat_q     <= rep_q;
      release_q    <= rel_q;
      cfg_err_q    <= err_q;
    end
  end

  assign vsync        = vsync_q;
  assign hsync        = hsync_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign ch_sel       = ch_sel_q;
  assign sel_blank    = sel_blank_q;
  assign sel_buf      = sel_buf_q;
  assign disp_buf     = disp_buf_q;
  assign wr_buf       = wr_buf_q;
  assign frame_done   = frame_done_q;
  assign repeat_frame = repeat_q;
  assign buf_release  = release_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_display_seq_ctrl.sv
// Directed bench for display_seq_ctrl with hb=2, vb=1, aip=4, ail=2, NUM_CH=3:
// frame timing, buffer swap/repeat, config error, mid-frame stop and async reset.
module tb_display_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_display = 1'b0;
  logic [9:0]  cfg_hb = 10'd2, cfg_vb = 10'd1, cfg_aip = 10'd4, cfg_ail = 10'd2;
  logic [1:0]  buf_full = 2'b01;
  logic        disp_buf, wr_buf, rd_en, sel_blank, sel_buf, hsync, vsync;
  logic [15:0] rd_addr;
  logic [2:0]  ch_sel;
  logic [1:0]  buf_release;
  logic        frame_done, repeat_frame, cfg_err;

  int n_chk = 0;
  int n_pass = 0;

  int n_rd, n_hs, n_vs, first_hs, hs_rd, done_at, addr_err, chsel_err, first_addr;
  int rep_done, rel_done, disp_done, wr_done, waited, quiet, n_err;

  display_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cs_display   (cs_display),
    .cfg_hb       (cfg_hb),
    .cfg_vb       (cfg_vb),
    .cfg_aip      (cfg_aip),
    .cfg_ail      (cfg_ail),
    .buf_full     (buf_full),
    .disp_buf     (disp_buf),
    .wr_buf       (wr_buf),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .ch_sel       (ch_sel),
    .sel_blank    (sel_blank),
    .sel_buf      (sel_buf),
    .hsync        (hsync),
    .vsync        (vsync),
    .buf_release  (buf_release),
    .frame_done   (frame_done),
    .repeat_frame (repeat_frame),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_start(input int bound);
    waited = -1;
    for (int i = 0; i < bound; i++) begin
      if (vsync || hsync || rd_en) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Cycle 0 is the current sample; expected rd_addr/ch_sel follow the k-th read.
  task automatic capture(input int ncyc, input int drop_at);
    int k;
    k = 0;
    n_hs = 0; n_vs = 0; first_hs = -1; hs_rd = 0; done_at = -1;
    addr_err = 0; chsel_err = 0; first_addr = -1;
    rep_done = -1; rel_done = -1; disp_done = -1; wr_done = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (vsync) n_vs++;
      if (hsync) begin
        n_hs++;
        if (first_hs < 0) first_hs = c;
        if (rd_en) hs_rd++;
      end
      if (rd_en) begin
        if (first_addr < 0) first_addr = int'(rd_addr);
        if (rd_addr != 16'(k / 3)) addr_err++;
        if (ch_sel != 3'(1 << (k % 3))) chsel_err++;
        k++;
      end
      if (frame_done) begin
        done_at   = c;
        rep_done  = int'(repeat_frame);
        rel_done  = int'(buf_release);
        disp_done = int'(disp_buf);
        wr_done   = int'(wr_buf);
      end
      if (c == drop_at) cs_display = 1'b0;
    end
    n_rd = k;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_bufs", int'({disp_buf, wr_buf}), 1);
    chk("rst_pulses", int'({vsync, hsync, frame_done, cfg_err, buf_release, sel_blank}), 0);
    repeat (3) @(negedge clk);
    cs_display = 1'b1;
    reset = 1'b1;

    // Frame 1: buf_full=01 -> repeat, next frame follows immediately.
    wait_start(20);
    chk("start_latency", waited, 3);
    capture(55, -1);
    chk("f1_rd_cnt", n_rd, 24);
    chk("f1_hsync_cnt", n_hs, 2);
    chk("f1_first_hsync", first_hs, 18);
    chk("f1_done_at", done_at, 54);
    chk("f1_addr_err", addr_err, 0);
    chk("f1_chsel_err", chsel_err, 0);
    chk("f1_repeat", rep_done, 1);
    chk("f1_disp_buf", disp_done, 0);
    chk("f1_vsync_cnt", n_vs, 2);

    // Frame 2: other buffer full -> swap to buffer 1, release buffer 0.
    buf_full = 2'b11;
    wait_start(5);
    chk("f2_start", waited, 0);
    capture(55, -1);
    chk("f2_done_at", done_at, 54);
    chk("f2_disp_buf", disp_done, 1);
    chk("f2_wr_buf", wr_done, 0);
    chk("f2_release", rel_done, 1);
    chk("f2_repeat", rep_done, 0);
    chk("f2_addr_err", addr_err, 0);

    // Frame 3: cs_display dropped at cycle 10; frame still completes.
    buf_full = 2'b01;
    capture(55, 10);
    chk("f3_done_at", done_at, 54);
    chk("f3_rd_cnt", n_rd, 24);
    chk("f3_vsync_cnt", n_vs, 1);
    chk("f3_release", rel_done, 2);
    chk("f3_disp_buf", disp_done, 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vsync || hsync || rd_en || sel_blank) quiet++;
    end
    chk("f3_idle_quiet", quiet, 0);

    // Zero active pixels: single cfg_err pulse, no frame.
    cfg_aip = 10'd0;
    cs_display = 1'b1;
    n_err = 0;
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_err) n_err++;
      if (rd_en || sel_blank || vsync) quiet++;
    end
    chk("cfgerr_pulses", n_err, 1);
    chk("cfgerr_no_frame", quiet, 0);
    cs_display = 1'b0;
    cfg_aip = 10'd4;
    repeat (3) @(negedge clk);

    // No blanking: hsync rides on the first read of each line, 24-cycle frame.
    cfg_hb = 10'd0;
    cfg_vb = 10'd0;
    cs_display = 1'b1;
    wait_start(10);
    chk("nb_start", waited, 2);
    capture(25, 5);
    chk("nb_done_at", done_at, 24);
    chk("nb_rd_cnt", n_rd, 24);
    chk("nb_hsync_on_rd", hs_rd, 2);
    chk("nb_first_hsync", first_hs, 0);
    chk("nb_addr_err", addr_err, 0);
    cfg_hb = 10'd2;
    cfg_vb = 10'd1;
    repeat (3) @(negedge clk);

    // Swap to buffer 1, then reset in ACTIVE of the following frame.
    buf_full = 2'b11;
    cs_display = 1'b1;
    wait_start(10);
    capture(55, -1);
    chk("ra_disp_buf", disp_done, 1);
    capture(30, -1);
    @(negedge clk);
    chk("pre_rst_rd_en", int'(rd_en), 1);
    chk("pre_rst_disp", int'(disp_buf), 1);
    reset = 1'b0;
    #1;
    chk("arst_rd_en", int'(rd_en), 0);
    chk("arst_disp", int'(disp_buf), 0);
    chk("arst_wr", int'(wr_buf), 1);
    chk("arst_outs", int'({ch_sel, sel_buf, sel_blank, hsync, vsync}), 0);
    chk("arst_addr", int'(rd_addr), 0);
    repeat (2) @(negedge clk);
    buf_full = 2'b01;
    reset = 1'b1;
    wait_start(20);
    chk("restart_latency", waited, 3);
    capture(30, 0);
    chk("restart_vsync", n_vs, 1);
    chk("restart_addr0", first_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
